// File: rtl/seg_scan_if.sv
// seg_scan_if: anode/segment scan inputs and decoded frame outputs of seg_scan_decoder.
// Latency: none (wiring only); SEG_SCAN_ERR_EN adds the err_count output.
// Backpressure: none, the scan lines and frame outputs are free-running.
interface seg_scan_if;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [3:0]  digit_ok;
  logic        frame_valid;
  logic        changed;
`ifdef SEG_SCAN_ERR_EN
  logic [7:0]  err_count;

  modport master (output an, seg, dp,
                  input  value, dp_mask, digit_ok, frame_valid, changed, err_count);
  modport slave  (input  an, seg, dp,
                  output value, dp_mask, digit_ok, frame_valid, changed, err_count);
`else
  modport master (output an, seg, dp,
                  input  value, dp_mask, digit_ok, frame_valid, changed);
  modport slave  (input  an, seg, dp,
                  output value, dp_mask, digit_ok, frame_valid, changed);
`endif
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a 4-digit multiplexed 7-segment scan into hex frames; SEG_SCAN_ERR_EN adds err_count.
// Latency: 2-cycle synchronizer, DWELL_MIN stable cycles per digit, frame commits 1 cycle after the 4th sample.
// Backpressure: none; frame_valid/changed are single-cycle pulses that are never held off.
module seg_scan_decoder #(
  parameter int unsigned DWELL_MIN = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DWELL, HELD, MULTI} state_t;

  localparam logic [7:0] CNT_LAST = 8'(DWELL_MIN - 1);

  state_t      state_q, state_d, cls_state;
  logic [7:0]  cnt_q, cnt_d, cls_cnt;
  logic [11:0] sync1_q, sync2_q, prev_q;
  logic [3:0]  s_an;
  logic [6:0]  s_seg;
  logic        s_dp;
  logic        in_chg, none_low, one_low, sample, commit;
  logic [1:0]  idx;
  logic [4:0]  dec;
  logic [15:0] stage_val_q, value_q;
  logic [3:0]  stage_dp_q, stage_ok_q, staged_q;
  logic [3:0]  dp_mask_q, digit_ok_q;
  logic        frame_valid_q, changed_q, first_q;

  // {ok, nibble}; unknown patterns and blank give ok=0 with nibble 0
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40:   decode = 5'h10;
      7'h79:   decode = 5'h11;
      7'h24:   decode = 5'h12;
      7'h30:   decode = 5'h13;
      7'h19:   decode = 5'h14;
      7'h12:   decode = 5'h15;
      7'h02:   decode = 5'h16;
      7'h78:   decode = 5'h17;
      7'h00:   decode = 5'h18;
      7'h10:   decode = 5'h19;
      7'h08:   decode = 5'h1A;
      7'h03:   decode = 5'h1B;
      7'h46:   decode = 5'h1C;
      7'h21:   decode = 5'h1D;
      7'h06:   decode = 5'h1E;
      7'h0E:   decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  assign s_an   = sync2_q[11:8];
  assign s_seg  = sync2_q[7:1];
  assign s_dp   = sync2_q[0];
  assign in_chg = (sync2_q != prev_q);
  assign dec    = decode(s_seg);
  assign commit = (staged_q == 4'hF);

  // two-flop synchronizer plus a copy of the previous synchronized pattern for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= {bus.an, bus.seg, bus.dp};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // classify the anode pattern: none low, exactly one low (with its index), or several low
  always_comb begin
    none_low = (s_an == 4'hF);
    one_low  = 1'b0;
    idx      = 2'd0;
    case (s_an)
      4'b1110: begin one_low = 1'b1; idx = 2'd0; end
      4'b1101: begin one_low = 1'b1; idx = 2'd1; end
      4'b1011: begin one_low = 1'b1; idx = 2'd2; end
      4'b0111: begin one_low = 1'b1; idx = 2'd3; end
      default: ;
    endcase
    if (none_low) begin
      cls_state = IDLE;
      cls_cnt   = 8'd0;
    end else if (one_low) begin
      cls_state = DWELL;
      cls_cnt   = 8'd1;
    end else begin
      cls_state = MULTI;
      cls_cnt   = 8'd0;
    end
  end

  // FSM state and dwell counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: count stable cycles in DWELL, sample on reaching DWELL_MIN, re-classify on any change
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sample  = 1'b0;
    case (state_q)
      IDLE, MULTI: begin
        state_d = cls_state;
        cnt_d   = cls_cnt;
      end
      DWELL: begin
        if (in_chg) begin
          state_d = cls_state;
          cnt_d   = cls_cnt;
        end else if (cnt_q == CNT_LAST) begin
          sample  = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          state_d = HELD;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      HELD: begin
        if (in_chg) begin
          state_d = cls_state;
          cnt_d   = cls_cnt;
        end
      end
      default: ;
    endcase
  end

  // staging slots and frame commit; a commit reads the old slots so a same-cycle sample opens the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_val_q   <= 16'h0000;
      stage_dp_q    <= 4'h0;
      stage_ok_q    <= 4'h0;
      staged_q      <= 4'h0;
      value_q       <= 16'h0000;
      dp_mask_q     <= 4'h0;
      digit_ok_q    <= 4'h0;
      frame_valid_q <= 1'b0;
      changed_q     <= 1'b0;
      first_q       <= 1'b1;
    end else begin
      frame_valid_q <= commit;
      changed_q     <= 1'b0;
      if (commit) begin
        value_q    <= stage_val_q;
        dp_mask_q  <= stage_dp_q;
        digit_ok_q <= stage_ok_q;
        changed_q  <= first_q ||
                      ({stage_val_q, stage_dp_q, stage_ok_q} != {value_q, dp_mask_q, digit_ok_q});
        first_q    <= 1'b0;
      end
      staged_q <= (commit ? 4'h0 : staged_q) | (sample ? (4'b0001 << idx) : 4'h0);
      if (sample) begin
        stage_val_q[{idx, 2'b00} +: 4] <= dec[3:0];
        stage_dp_q[idx]                <= ~s_dp;
        stage_ok_q[idx]                <= dec[4];
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.dp_mask     = dp_mask_q;
  assign bus.digit_ok    = digit_ok_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.changed     = changed_q;

`ifdef SEG_SCAN_ERR_EN
  logic [7:0] err_q;
  logic       err_inc;

  assign err_inc = ((state_q != MULTI) && (state_d == MULTI)) ||
                   (sample && !dec[4] && (s_seg != 7'h7F));

  // saturating count of MULTI entries and undecodable non-blank samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 8'h00;
    end else if (err_inc && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'h01;
    end
  end

  assign bus.err_count = err_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: randomized and directed scan stimulus against a per-cycle pattern model.
// Expected frames are queued at stimulus time and popped by a monitor on each frame_valid.
// The monitor owns all comparisons and prints the summary.
module tb_seg_scan_decoder;
  localparam int DW = 4;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dpm;
    logic [3:0]  ok;
    logic        chg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_if bus();

  seg_scan_decoder #(.DWELL_MIN(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   failures = 0;
  bit   zero_req = 1'b0;
  bit   end_req = 1'b0;
  exp_t exp_q[$];

  logic [6:0]  seg_tab [16];
  logic [11:0] m_last;
  int          m_run;
  logic [3:0]  m_staged;
  logic [3:0]  m_nib [4];
  logic [3:0]  m_dp;
  logic [3:0]  m_ok;
  logic [23:0] m_prev;
  bit          m_first;
  int          m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    m_last   = 12'hFFF;
    m_run    = 0;
    m_staged = 4'h0;
    m_first  = 1'b1;
    m_err    = 0;
  endtask

  task automatic err_bump();
    if (m_err < 255) m_err++;
  endtask

  // one cycle of input: any pattern held DWELL_MIN consecutive cycles with one anode low is a sample
  task automatic model_step(input logic [3:0] a, input logic [6:0] s, input logic d);
    logic [11:0] pat;
    int idx, nib;
    bit ok;
    exp_t e;
    pat = {a, s, d};
    if (pat == m_last) m_run++;
    else m_run = 1;
    if ($countones(~a) > 1 && $countones(~m_last[11:8]) <= 1) err_bump();
    m_last = pat;
    if (m_run == DW && $countones(~a) == 1) begin
      idx = 0;
      for (int k = 0; k < 4; k++) if (!a[k]) idx = k;
      ok = 1'b0;
      nib = 0;
      for (int k = 0; k < 16; k++) if (seg_tab[k] == s) begin ok = 1'b1; nib = k; end
      if (!ok && s != 7'h7F) err_bump();
      m_nib[idx]    = nib[3:0];
      m_dp[idx]     = ~d;
      m_ok[idx]     = ok;
      m_staged[idx] = 1'b1;
      if (m_staged == 4'hF) begin
        e.value = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
        e.dpm   = m_dp;
        e.ok    = m_ok;
        e.chg   = m_first || ({e.value, e.dpm, e.ok} != m_prev);
        exp_q.push_back(e);
        m_prev   = {e.value, e.dpm, e.ok};
        m_first  = 1'b0;
        m_staged = 4'h0;
      end
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.an  = a;
      bus.seg = s;
      bus.dp  = d;
      model_step(a, s, d);
    end
  endtask

  task automatic digit(input int pos, input logic [6:0] s, input logic d, input int n);
    logic [3:0] a;
    a = 4'hF;
    a[pos] = 1'b0;
    drive(a, s, d, n);
  endtask

  task automatic idle(input int n);
    drive(4'hF, 7'h7F, 1'b1, n);
  endtask

  task automatic pulse_zero_check();
    @(posedge clk);
    #1 zero_req = 1'b1;
    @(posedge clk);
    #1 zero_req = 1'b0;
  endtask

  // monitor: frame scoreboard, reset-value checks and end-of-run summary
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.frame_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame actual value=%h dp_mask=%h digit_ok=%h expected none",
                 bus.value, bus.dp_mask, bus.digit_ok);
      end else begin
        e = exp_q.pop_front();
        check("frame_value", 32'(bus.value), 32'(e.value));
        check("frame_dp_mask", 32'(bus.dp_mask), 32'(e.dpm));
        check("frame_digit_ok", 32'(bus.digit_ok), 32'(e.ok));
        check("frame_changed", 32'(bus.changed), 32'(e.chg));
      end
    end
    if (zero_req) begin
      check("rst_value", 32'(bus.value), 32'h0);
      check("rst_dp_mask", 32'(bus.dp_mask), 32'h0);
      check("rst_digit_ok", 32'(bus.digit_ok), 32'h0);
      check("rst_frame_valid", 32'(bus.frame_valid), 32'h0);
      check("rst_changed", 32'(bus.changed), 32'h0);
`ifdef SEG_SCAN_ERR_EN
      check("rst_err_count", 32'(bus.err_count), 32'h0);
`endif
    end
    if (end_req) begin
      check("frames_outstanding", 32'(exp_q.size()), 32'h0);
`ifdef SEG_SCAN_ERR_EN
      check("err_count", 32'(bus.err_count), 32'(m_err));
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    logic [3:0] a;
    logic [6:0] s;
    int r;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    bus.an  = 4'hF;
    bus.seg = 7'h7F;
    bus.dp  = 1'b1;
    model_reset();
    pulse_zero_check();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(5);

    // scan 1,2,3,4 twice: first frame changed, identical repeat unchanged
    repeat (2) begin
      digit(0, 7'h19, 1'b1, 8);
      digit(1, 7'h30, 1'b1, 8);
      digit(2, 7'h24, 1'b1, 8);
      digit(3, 7'h79, 1'b1, 8);
    end
    idle(10);

    // digit 0 held one cycle short: not staged, so no frame until it is rescanned
    digit(0, seg_tab[5], 1'b1, DW - 1);
    digit(1, seg_tab[6], 1'b1, 8);
    digit(2, seg_tab[7], 1'b1, 8);
    digit(3, seg_tab[8], 1'b1, 8);
    idle(10);
    digit(0, seg_tab[5], 1'b1, 8);
    idle(10);

    // two anodes low for 20 cycles mid-scan
    digit(0, seg_tab[10], 1'b1, 8);
    digit(1, seg_tab[11], 1'b1, 8);
    drive(4'b1100, seg_tab[12], 1'b1, 20);
    digit(2, seg_tab[12], 1'b1, 8);
    digit(3, seg_tab[13], 1'b1, 8);
    idle(10);

    // blank digit 2 and decimal point on digit 0
    digit(0, seg_tab[9], 1'b0, 8);
    digit(1, seg_tab[3], 1'b1, 8);
    digit(2, 7'h7F, 1'b1, 8);
    digit(3, seg_tab[15], 1'b1, 8);
    idle(10);

    // randomized holds: mostly single anodes, some idle, multi, blank and garbage patterns
    for (int h = 0; h < 300; h++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        a = 4'hF;
        a[$urandom_range(0, 3)] = 1'b0;
      end else if (r < 85) begin
        a = 4'hF;
      end else begin
        a = 4'($urandom_range(0, 15));
        if ($countones(~a) < 2) a = 4'b0101;
      end
      r = $urandom_range(0, 99);
      if (r < 75) s = seg_tab[$urandom_range(0, 15)];
      else if (r < 85) s = 7'h7F;
      else s = 7'($urandom);
      drive(a, s, 1'($urandom_range(0, 1)), $urandom_range(1, DW + 6));
    end
    idle(20);

    // reset after three staged digits; one fresh digit afterwards must not produce a frame
    digit(0, seg_tab[1], 1'b1, 8);
    digit(1, seg_tab[2], 1'b1, 8);
    digit(2, seg_tab[3], 1'b1, 8);
    idle(8);
    @(posedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);
    digit(3, seg_tab[4], 1'b1, 8);
    idle(10);
    pulse_zero_check();

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1 end_req = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL summary_not_reached actual=running expected=finished");
    $fatal(1);
  end
endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter DWELL_MIN, default 4: cycles that anode and segment inputs must hold unchanged before a digit is sampled; legal range 2..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 an  input  4  multiplexed digit anodes, active-low; an[0] = rightmost digit.
REQ-005 seg  input  7  segment lines, active-low; seg[0]=a ... seg[6]=g.
REQ-006 dp  input  1  decimal point, active-low.
REQ-007 value  output  16  last complete frame; value[3:0] = digit 0.
REQ-008 dp_mask  output  4  decimal-point state per digit of the last frame, 1 = lit.
REQ-009 digit_ok  output  4  per digit of the last frame, 1 = pattern decoded as hex 0-F.
REQ-010 frame_valid  output  1  one-cycle pulse when value/dp_mask/digit_ok update.
REQ-011 changed  output  1  one-cycle pulse coincident with frame_valid when the new {value, dp_mask, digit_ok} differs from the previous one.

Function
REQ-012 Inputs pass through a 2-flop synchronizer; all further behaviour refers to synchronized values, adding 2 cycles of latency.
REQ-013 FSM states: IDLE (no anode low), DWELL (exactly one anode low, counting), HELD (digit sampled, waiting for a change), MULTI (more than one anode low).
REQ-014 IDLE -> DWELL when exactly one anode is low; the dwell counter loads 1.
REQ-015 DWELL: the counter increments each cycle an, seg and dp are unchanged; any change restarts the counter at 1 (or changes state per REQ-013 classification).
REQ-016 When the counter reaches DWELL_MIN, the digit is sampled into a staging slot indexed by the active anode, its staged bit is set, and the FSM enters HELD.
REQ-017 HELD: no further sampling until an, seg or dp change; then the FSM re-classifies to IDLE, DWELL or MULTI.
REQ-018 MULTI: nothing is sampled; exit to IDLE or DWELL when the condition clears.
REQ-019 Decode, active-low a..g: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
REQ-020 Any other pattern, including blank 7'h7F, stages nibble 4'h0 with digit_ok=0.
REQ-021 When all four staged bits are set, the next cycle copies the staging slots to the outputs, pulses frame_valid, evaluates changed, and clears all staged bits.
REQ-022 Re-sampling a digit already staged in the current frame overwrites its slot; the latest sample wins.
REQ-023 A sample that completes a frame and a new sample arriving in the same cycle: the completing frame commits first; the new sample becomes the first entry of the next frame.
REQ-024 The first frame after reset always asserts changed.

Reset
REQ-025 When rst_n is low: value=16'h0000, dp_mask=4'h0, digit_ok=4'h0, frame_valid=0, changed=0, FSM=IDLE, counter=0, staged bits cleared, synchronizers=all ones.
REQ-026 If reset occurs mid-frame, the partial frame is discarded, and no frame_valid is issued until four fresh digits have been sampled.

Configuration
REQ-027 Macro SEG_SCAN_ERR_EN.
- Defined: adds output err_count (8 bits, saturating at 8'hFF, reset 0).
- err_count increments once on each entry to MULTI and once on each sample that gives digit_ok=0 while the pattern is not blank.
- Undefined: no err_count port exists, and the rest of the behaviour is identical.

Verification
REQ-028 Scan 1,2,3,4 with dwell 8 per digit: an=4'b1110 with seg=7'h19, then an[1] with seg=7'h30, then 7'h24, then 7'h79 -> value=16'h1234, digit_ok=4'hF, and one frame_valid with changed=1.
REQ-029 Repeat the identical scan a second time -> frame_valid=1, changed=0.
REQ-030 Hold a digit for DWELL_MIN-1 cycles before moving to the next anode -> that digit is never staged, and no frame_valid is issued.
REQ-031 Drive an=4'b1100 for 20 cycles during a scan -> nothing is sampled; with SEG_SCAN_ERR_EN defined, err_count=1.
REQ-032 Scan with digit 2 blank (7'h7F) and dp low on digit 0 -> digit_ok=4'b1011, value[11:8]=4'h0, dp_mask=4'b0001.
REQ-033 Assert rst_n low after three digits are staged, then release and send one digit -> no frame_valid, and all outputs stay at their reset values.
